dram_request_bridge: RTL and testbench

DRAM_REQUEST_BRIDGE -- requirements
Module: dram_request_bridge

---
 rtl/dram_request_bridge_if.sv | 42 ++++
 rtl/dram_request_bridge.sv | 99 +++++++++
 tb/tb_dram_request_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_request_bridge_if.sv
// Cache-side and DRAM-side signal bundle for the DRAM request bridge.
// The slave modport is the bridge view; master is the view of its surroundings.
interface dram_request_bridge_if;
  logic         cache_req_valid;
  logic         cache_req_ready;
  logic [21:0]  cache_req_addr_read;
  logic [10:0]  cache_req_addr_write_upper;
  logic         cache_req_dirty;
  logic [127:0] cache_req_lane;
  logic         cache_rsp_valid;
  logic         cache_rsp_ready;
  logic [127:0] cache_rsp_lane;
  logic         cache_rsp_timeout;
  logic [10:0]  addr_req_read_dram_side_dram;
  logic [10:0]  addr_req_write_dram_side_dram;
  logic [10:0]  addr_req_common_side_dram;
  logic [127:0] lane_from_cache_to_dram_side_dram;
  logic         dram_controller_entry_dirty_side_dram;
  logic         dram_controller_req_read_pulse_side_dram;
  logic         dram_controller_ack_read_pulse_side_dram;
  logic [127:0] lane_from_dram_to_cache_side_dram;

  modport slave (
    input  cache_req_valid, cache_req_addr_read, cache_req_addr_write_upper,
           cache_req_dirty, cache_req_lane, cache_rsp_ready,
           dram_controller_ack_read_pulse_side_dram, lane_from_dram_to_cache_side_dram,
    output cache_req_ready, cache_rsp_valid, cache_rsp_lane, cache_rsp_timeout,
           addr_req_read_dram_side_dram, addr_req_write_dram_side_dram,
           addr_req_common_side_dram, lane_from_cache_to_dram_side_dram,
           dram_controller_entry_dirty_side_dram, dram_controller_req_read_pulse_side_dram
  );

  modport master (
    output cache_req_valid, cache_req_addr_read, cache_req_addr_write_upper,
           cache_req_dirty, cache_req_lane, cache_rsp_ready,
           dram_controller_ack_read_pulse_side_dram, lane_from_dram_to_cache_side_dram,
    input  cache_req_ready, cache_rsp_valid, cache_rsp_lane, cache_rsp_timeout,
           addr_req_read_dram_side_dram, addr_req_write_dram_side_dram,
           addr_req_common_side_dram, lane_from_cache_to_dram_side_dram,
           dram_controller_entry_dirty_side_dram, dram_controller_req_read_pulse_side_dram
  );
endinterface

// File: rtl/dram_request_bridge.sv
// Single-outstanding bridge from cache miss requests to a pulse/ack DRAM controller,
// re-issuing the read pulse whenever the ack does not arrive within TIMEOUT_CYCLES.
module dram_request_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               main_clk,
  input logic               reset,
  dram_request_bridge_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, RESP} state_t;

  state_t       state_q;
  logic         ready_q;
  logic         pulse_q;
  logic         rsp_valid_q;
  logic         timeout_q;
  logic         dirty_q;
  logic [CNT_W-1:0] cnt_q;
  logic [10:0]  rd_upper_q;
  logic [10:0]  wr_upper_q;
  logic [10:0]  common_q;
  logic [127:0] wb_lane_q;
  logic [127:0] fill_lane_q;

  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      pulse_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      dirty_q     <= 1'b0;
      cnt_q       <= '0;
      rd_upper_q  <= '0;
      wr_upper_q  <= '0;
      common_q    <= '0;
      wb_lane_q   <= '0;
      fill_lane_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // ready comes up one edge after reset release, then stays until a request is taken
          ready_q <= 1'b1;
          if (bus.cache_req_valid && ready_q) begin
            rd_upper_q <= bus.cache_req_addr_read[21:11];
            common_q   <= bus.cache_req_addr_read[10:0];
            wr_upper_q <= bus.cache_req_addr_write_upper;
            dirty_q    <= bus.cache_req_dirty;
            wb_lane_q  <= bus.cache_req_lane;
            ready_q    <= 1'b0;
            pulse_q    <= 1'b1;
            state_q    <= PULSE;
          end
        end
        PULSE: begin
          pulse_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // an ack arriving on the expiry cycle takes priority over the retry
          if (bus.dram_controller_ack_read_pulse_side_dram) begin
            fill_lane_q <= bus.lane_from_dram_to_cache_side_dram;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            pulse_q   <= 1'b1;
            state_q   <= PULSE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.cache_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cache_req_ready                          = ready_q;
  assign bus.cache_rsp_valid                          = rsp_valid_q;
  assign bus.cache_rsp_lane                           = fill_lane_q;
  assign bus.cache_rsp_timeout                        = timeout_q;
  assign bus.addr_req_read_dram_side_dram             = rd_upper_q;
  assign bus.addr_req_write_dram_side_dram            = wr_upper_q;
  assign bus.addr_req_common_side_dram                = common_q;
  assign bus.lane_from_cache_to_dram_side_dram        = wb_lane_q;
  assign bus.dram_controller_entry_dirty_side_dram    = dirty_q;
  assign bus.dram_controller_req_read_pulse_side_dram = pulse_q;
endmodule

// File: tb/tb_dram_request_bridge.sv
// Scoreboard bench for dram_request_bridge: a driver issues cache requests, a DRAM
// responder answers pulses (or lets them time out), and a monitor checks responses.
module tb_dram_request_bridge;
  localparam int TO = 8;

  typedef struct {
    int           id;
    int           acc;
    logic [21:0]  a;
    logic [10:0]  wu;
    logic         d;
    logic [127:0] l;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  req_t         reqq[$];
  logic [127:0] rspq[$];
  int           plan[$];
  int           ack_cyc = -1;
  logic         tmo_exp = 1'b0;
  int           n_done = 0;
  int           hold_next = 0;
  int           spur_n = 0;
  int           spur_done = 0;
  int           next_id = 0;
  int           n_expect = 0;

  dram_request_bridge_if bus();

  dram_request_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .main_clk(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(bus.cache_req_ready), 128'(0));
    chk({tag, "_pulse"}, 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(bus.cache_rsp_valid), 128'(0));
    chk({tag, "_rsp_timeout"}, 128'(bus.cache_rsp_timeout), 128'(0));
    chk({tag, "_rsp_lane"}, bus.cache_rsp_lane, 128'(0));
    chk({tag, "_wb_lane"}, bus.lane_from_cache_to_dram_side_dram, 128'(0));
    chk({tag, "_rd_addr"}, 128'(bus.addr_req_read_dram_side_dram), 128'(0));
    chk({tag, "_wr_addr"}, 128'(bus.addr_req_write_dram_side_dram), 128'(0));
    chk({tag, "_cm_addr"}, 128'(bus.addr_req_common_side_dram), 128'(0));
    chk({tag, "_dirty"}, 128'(bus.dram_controller_entry_dirty_side_dram), 128'(0));
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [21:0] a, input logic [10:0] wu, input logic d,
                       input logic [127:0] l);
    int   n = 0;
    req_t r;
    bus.cache_req_valid            = 1'b1;
    bus.cache_req_addr_read        = a;
    bus.cache_req_addr_write_upper = wu;
    bus.cache_req_dirty            = d;
    bus.cache_req_lane             = l;
    while (bus.cache_req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      chk("req_accept_bound", 128'(0), 128'(1));
      bus.cache_req_valid = 1'b0;
      return;
    end
    r.id = next_id; r.acc = cyc; r.a = a; r.wu = wu; r.d = d; r.l = l;
    reqq.push_back(r);
    next_id++;
    n_expect++;
    @(negedge clk);
    bus.cache_req_valid            = 1'b0;
    bus.cache_req_addr_read        = 22'($urandom);
    bus.cache_req_addr_write_upper = 11'($urandom);
    bus.cache_req_dirty            = 1'($urandom);
    bus.cache_req_lane             = rnd128();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (n_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("responses_done", 128'(n_done), 128'(target));
  endtask

  // DRAM controller model: one ack per pulse after a chosen delay, or none (timeout).
  initial begin : responder
    int   last_id = -1;
    int   last_p = 0;
    int   skips = 0;
    int   d;
    req_t r;
    logic [127:0] ln;
    bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
    bus.lane_from_dram_to_cache_side_dram        = '0;
    forever begin
      @(negedge clk);
      bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
      if (spur_n != spur_done) begin
        spur_done++;
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram        = rnd128();
      end
      if (rst) begin
        tmo_exp = 1'b0;
        last_id = -1;
        continue;
      end
      if (bus.dram_controller_req_read_pulse_side_dram === 1'b1) begin
        chk("pulse_has_request", 128'(reqq.size() != 0), 128'(1));
        if (reqq.size() != 0) begin
          r = reqq[0];
          if (r.id != last_id) begin
            chk("pulse_first_cycle", 128'(cyc), 128'(r.acc + 1));
            skips = 0;
          end else begin
            chk("pulse_retry_cycle", 128'(cyc), 128'(last_p + TO + 1));
          end
          chk("pulse_timeout_flag", 128'(bus.cache_rsp_timeout), 128'(tmo_exp));
          last_id = r.id;
          last_p  = cyc;
          if (plan.size() != 0) d = plan.pop_front();
          else if (skips == 0 && $urandom_range(0, 5) == 0) d = -1;
          else d = $urandom_range(1, TO);
          if (d < 0) begin
            tmo_exp = 1'b1;
            skips++;
          end else begin
            repeat (d) @(negedge clk);
            ln = rnd128();
            bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
            bus.lane_from_dram_to_cache_side_dram        = ln;
            rspq.push_back(ln);
            ack_cyc = cyc;
            @(negedge clk);
            bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
              bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
              bus.lane_from_dram_to_cache_side_dram        = rnd128();
            end
          end
        end
      end
    end
  end

  // Response consumer and output monitor.
  initial begin : monitor
    logic prev_v = 1'b0;
    int   hold = 0;
    bit   rdy_chk = 1'b0;
    logic exp_v;
    req_t r;
    bus.cache_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        reqq.delete();
        rspq.delete();
        prev_v  = 1'b0;
        hold    = 0;
        rdy_chk = 1'b0;
        bus.cache_rsp_ready = 1'b0;
        continue;
      end
      if (bus.cache_rsp_valid === 1'b1 && !prev_v) hold = hold_next;
      if (hold > 0) begin
        bus.cache_rsp_ready = 1'b0;
        hold--;
      end else begin
        bus.cache_rsp_ready = ($urandom_range(0, 9) < 6);
      end
      exp_v = (rspq.size() != 0) && (cyc > ack_cyc);
      chk("rsp_valid", 128'(bus.cache_rsp_valid), 128'(exp_v));
      if (bus.cache_rsp_valid === 1'b1 && rspq.size() != 0) begin
        chk("rsp_lane", bus.cache_rsp_lane, rspq[0]);
        if (bus.cache_rsp_ready)
          chk("rsp_timeout_flag", 128'(bus.cache_rsp_timeout), 128'(tmo_exp));
      end
      if (reqq.size() != 0 && cyc > reqq[0].acc) begin
        r = reqq[0];
        chk("req_ready_busy", 128'(bus.cache_req_ready), 128'(0));
        chk("dram_rd_addr", 128'(bus.addr_req_read_dram_side_dram), 128'(r.a[21:11]));
        chk("dram_cm_addr", 128'(bus.addr_req_common_side_dram), 128'(r.a[10:0]));
        chk("dram_wr_addr", 128'(bus.addr_req_write_dram_side_dram), 128'(r.wu));
        chk("dram_dirty", 128'(bus.dram_controller_entry_dirty_side_dram), 128'(r.d));
        chk("dram_wb_lane", bus.lane_from_cache_to_dram_side_dram, r.l);
      end
      if (rdy_chk) begin
        chk("req_ready_after_rsp", 128'(bus.cache_req_ready), 128'(1));
        rdy_chk = 1'b0;
      end
      if (bus.cache_rsp_valid === 1'b1 && bus.cache_rsp_ready) begin
        if (rspq.size() != 0) void'(rspq.pop_front());
        if (reqq.size() != 0) void'(reqq.pop_front());
        rdy_chk = 1'b1;
        n_done++;
      end
      prev_v = bus.cache_rsp_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int           n;
    logic [127:0] lane_before;
    bus.cache_req_valid            = 1'b0;
    bus.cache_req_addr_read        = '0;
    bus.cache_req_addr_write_upper = '0;
    bus.cache_req_dirty            = 1'b0;
    bus.cache_req_lane             = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 128'(bus.cache_req_ready), 128'(1));

    // Basic clean read
    repeat (6) @(negedge clk);
    plan.push_back(5);
    issue(22'h12345, 11'h000, 1'b0, 128'h0);
    wait_done(n_expect);

    // Dirty write-back held while the response is back-pressured for 20 cycles
    hold_next = 20;
    plan.push_back(3);
    issue(22'h12345, 11'h7FF, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
    n = 0;
    while (bus.cache_rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", 128'(bus.cache_rsp_valid), 128'(1));
    @(negedge clk);
    hold_next = 0;
    issue(22'($urandom), 11'($urandom), 1'b1, rnd128());
    wait_done(n_expect);

    // One timeout then ack; then ack exactly on the expiry cycle
    plan.push_back(-1);
    plan.push_back(3);
    issue(22'h2ABCD, 11'h155, 1'b0, rnd128());
    wait_done(n_expect);
    plan.push_back(TO);
    issue(22'h3FFFF, 11'h001, 1'b1, rnd128());
    wait_done(n_expect);

    // Spurious ack while idle
    repeat (2) @(negedge clk);
    lane_before = bus.cache_rsp_lane;
    spur_n++;
    repeat (4) @(negedge clk);
    chk("idle_ack_rsp_valid", 128'(bus.cache_rsp_valid), 128'(0));
    chk("idle_ack_rsp_lane", bus.cache_rsp_lane, lane_before);

    // Reset while waiting for the ack
    plan.push_back(-1);
    issue(22'h0F0F0, 11'h0AA, 1'b1, rnd128());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n_expect--;
    @(negedge clk);
    chk_zero("mid_reset");
    spur_n++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_mid_reset", 128'(bus.cache_req_ready), 128'(1));
    spur_n++;
    repeat (4) @(negedge clk);
    chk("post_reset_ack_rsp_valid", 128'(bus.cache_rsp_valid), 128'(0));
    chk("post_reset_ack_rsp_lane", bus.cache_rsp_lane, 128'(0));
    chk("post_reset_pulse", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(0));

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(22'($urandom), 11'($urandom), 1'($urandom), rnd128());
    end
    wait_done(n_expect);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
